// File: rtl/layer_weight_sequencer_pkg.sv
// Shared types and helpers for the fully-connected layer weight sequencer.
// Holds the FSM state encoding, width helpers and the output saturation rule.
package nar_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int N_DEF     = 8;
  localparam int Q_DEF     = 7;
  localparam int N_IN_DEF  = 16;
  localparam int N_OUT_DEF = 8;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: full product plus growth for n_in additions.
  function automatic int acc_w(input int n, input int n_in);
    return 2 * n + $clog2(n_in);
  endfunction

  localparam int ACC_W = acc_w(N_DEF, N_IN_DEF);

  // Clamp a signed value into the range of an n-bit two's complement word.
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                               input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/layer_weight_sequencer_fxp_mac.sv
// Signed N x N multiply-accumulate with load/accumulate select.
// Result is the accumulator scaled back by Q fractional bits and saturated to N bits.
module fxp_mac
  import nar_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int Q    = 7,
  parameter int N_IN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] res
);

  localparam int AW = acc_w(N, N_IN);

  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  acc_d;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  shifted;

  always_comb begin
    prod     = a * b;
    prod_ext = AW'(prod);
    acc_d    = acc_q;
    if (en) begin
      acc_d = load ? prod_ext : (acc_q + prod_ext);
    end
    // Arithmetic shift floors toward -inf before clamping to the output range.
    shifted = acc_q >>> Q;
    res     = N'(sat_n(64'(shifted), N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/layer_weight_sequencer.sv
// Walks the weights ROM and input buffer once per output neuron, accumulates the
// dot product in fixed point and hands each saturated result out over valid/ready.
module layer_weight_sequencer
  import nar_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int Q     = 7,
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int BASE  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  rom_addr,
  input  logic signed [N-1:0]         rom_data,
  output logic [idx_w(N_IN)-1:0]      x_addr,
  input  logic signed [N-1:0]         x_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [N-1:0]         out_data,
  output logic [idx_w(N_OUT)-1:0]     out_idx
);

  localparam int XW = idx_w(N_IN);
  localparam int JW = idx_w(N_OUT);
  localparam logic [XW-1:0] I_LAST = XW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  seq_state_e    state_d, state_q;
  logic [XW-1:0] i_d, i_q;
  logic [JW-1:0] j_d, j_q;
  logic [7:0]    rom_addr_d, rom_addr_q;
  logic [XW-1:0] x_addr_d, x_addr_q;
  logic          mac_en;
  logic          mac_load;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    mac_en   = 1'b0;
    mac_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          i_d     = '0;
          j_d     = '0;
        end
      end
      FETCH: begin
        // Data for the address presented this cycle arrives at the closing edge.
        mac_en   = 1'b1;
        mac_load = (i_q == '0);
        if (i_q == I_LAST) begin
          state_d = OUT;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          i_d = '0;
          if (j_q == J_LAST) begin
            state_d = DONE;
            j_d     = '0;
          end else begin
            state_d = FETCH;
            j_d     = j_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Addresses are registered from the next-cycle counters so they line up with FETCH.
    rom_addr_d = 8'(BASE + N_IN * int'(j_d) + int'(i_d));
    x_addr_d   = i_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      rom_addr_q <= 8'(BASE);
      x_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rom_addr_q <= rom_addr_d;
      x_addr_q   <= x_addr_d;
    end
  end

  fxp_mac #(
    .N    (N),
    .Q    (Q),
    .N_IN (N_IN)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (mac_en),
    .load (mac_load),
    .a    (rom_data),
    .b    (x_data),
    .res  (out_data)
  );

  assign busy      = (state_q == FETCH) || (state_q == OUT);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == OUT);
  assign out_idx   = j_q;
  assign rom_addr  = rom_addr_q;
  assign x_addr    = x_addr_q;

endmodule

// File: tb/tb_layer_weight_sequencer.sv
// Randomized self-checking bench for layer_weight_sequencer with a dot-product reference model.
module tb_layer_weight_sequencer;

  localparam int N     = 8;
  localparam int Q     = 7;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int BASE  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, done, out_valid;
  logic [7:0]        rom_addr;
  logic [1:0]        x_addr;
  logic signed [7:0] rom_data, x_data;
  logic signed [7:0] out_data;
  logic              out_idx;

  byte rom[256];
  byte xb[N_IN];

  int checks = 0;
  int errors = 0;

  layer_weight_sequencer #(
    .N(N), .Q(Q), .N_IN(N_IN), .N_OUT(N_OUT), .BASE(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  // Memories register their read data on the falling edge.
  always @(negedge clk) begin
    rom_data <= rom[rom_addr];
    x_data   <= xb[x_addr];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, floor-divided by 2^Q, clamped to N bits.
  function automatic int model(input int j);
    int s = 0;
    for (int i = 0; i < N_IN; i++) begin
      s += int'(rom[BASE + j * N_IN + i]) * int'(xb[i]);
    end
    s = s >>> Q;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_addr"}, rom_addr, BASE);
    chk({tag, "_x_addr"}, x_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
  endtask

  // mode 0: ready tied high, 1: hold ready low 7 cycles on neuron 0, 2: random ready
  task automatic run_pass(input int mode, input bit glitch, input int rst_cyc);
    int cyc, nres, stalls, done_cnt, done_cyc, fi, hold, prev_d, prev_i;
    bit prev_v, prev_hs, hs, fin;
    int exp_r[N_OUT];
    for (int j = 0; j < N_OUT; j++) exp_r[j] = model(j);
    nres = 0; stalls = 0; done_cnt = 0; done_cyc = 0; fi = 0; hold = 0;
    prev_d = 0; prev_i = 0; prev_v = 0; prev_hs = 0; fin = 0;
    start = 1'b1;
    out_ready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc <= 300) begin
      hs = 0;
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin
          chk("rst_no_done", done, 0);
          chk("rst_no_valid", out_valid, 0);
          @(posedge clk); #1;
        end
        return;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_in_done", busy, 0);
        chk("valid_in_done", out_valid, 0);
        fin = 1;
      end else begin
        chk("busy", busy, 1);
        if (out_valid) begin
          if (prev_v && !prev_hs) begin
            chk("hold_data", out_data, prev_d);
            chk("hold_idx", out_idx, prev_i);
          end else if (nres < N_OUT) begin
            chk("result", out_data, exp_r[nres]);
            chk("out_idx", out_idx, nres);
            if (nres == 0) chk("latency", cyc, N_IN + 1);
          end else begin
            chk("extra_result", nres, N_OUT - 1);
          end
          prev_d = int'(out_data);
          prev_i = int'(out_idx);
          case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (nres != 0) || (hold >= 7);
            default: out_ready = 1'($urandom_range(0, 1));
          endcase
          if (!out_ready) begin
            stalls++;
            hold++;
          end
          hs = out_ready;
          if (hs) nres++;
          fi = 0;
        end else begin
          chk("rom_addr", rom_addr, BASE + nres * N_IN + fi);
          chk("x_addr", x_addr, fi);
          fi = (fi + 1) % N_IN;
          if (mode == 2) out_ready = 1'($urandom_range(0, 1));
          else if (mode == 1) out_ready = (nres != 0) || (hold >= 7);
        end
      end
      start = glitch && (cyc == 2 || cyc == N_IN + 1);
      prev_v = out_valid;
      prev_hs = hs;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_count", done_cnt, 1);
    chk("n_results", nres, N_OUT);
    chk("pass_len", done_cyc, N_OUT * (N_IN + 1) + stalls + 1);
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_valid", out_valid, 0);
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) rom[a] = byte'($urandom);
    for (int i = 0; i < N_IN; i++) xb[i] = byte'($urandom);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'h20;
    for (int i = 0; i < N_IN; i++) xb[i] = 8'h40;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // 0x20 * 0x40 summed four times -> 0x40 for both neurons
    chk("model_basic", model(0), 64);
    run_pass(0, 1'b0, 0);

    // Positive saturation on neuron 0, negative on neuron 1, with a 7-cycle stall
    for (int i = 0; i < N_IN; i++) begin
      rom[BASE + i]        = 8'h40;
      rom[BASE + N_IN + i] = byte'(8'h80);
      xb[i]                = 8'h7F;
    end
    run_pass(1, 1'b0, 0);

    // Distinct weights per address, start pulsed during the pass
    fill_random();
    run_pass(0, 1'b1, 0);

    // Reset in the middle of neuron 1, then a clean pass from neuron 0
    fill_random();
    run_pass(0, 1'b0, 7);
    run_pass(0, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_pass(2, 1'(k % 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_weight_sequencer.md
# layer_weight_sequencer

Controller for the weights ROM in one fully-connected layer. On `start` it walks the ROM and the layer input buffer once per output neuron. Each weight × input product is accumulated in Qx.Q fixed point. Every finished neuron is presented as a saturated N-bit result on a valid/ready output port. The block sits between the layer-level control FSM, the weights ROM, the input-activation buffer and the activation stage.

## Interface
- `N`, 8, data word width (weights, inputs, outputs), signed
- `Q`, 7, fractional bits of every N-bit word
- `N_IN`, 16, inputs per neuron (≥1)
- `N_OUT`, 8, neurons in the layer (≥1)
- `BASE`, 0, first ROM address of this layer; BASE + N_IN·N_OUT ≤ 256
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a layer pass; sampled only in IDLE
- `busy`  out  1  high from the cycle after start is accepted through the final output handshake cycle
- `done`  out  1  one-cycle pulse after the last neuron's handshake
- `rom_addr`  out  8  weights ROM address, registered
- `rom_data`  in  N  signed weight returned by the ROM
- `x_addr`  out  $clog2(N_IN) (min 1)  input-buffer index, registered
- `x_data`  in  N  signed input activation
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  N  signed, saturated neuron result
- `out_idx`  out  $clog2(N_OUT) (min 1)  neuron index of `out_data`

## Operation
- FSM states: IDLE, FETCH, OUT, DONE.
- IDLE → FETCH when `start`=1. Neuron counter `j` and input counter `i` are cleared.
- FETCH presents `rom_addr` = BASE + j·N_IN + i and `x_addr` = i for one cycle per `i`.
- Product p = `rom_data` × `x_data` is 2N bits wide with 2Q fractional bits.
- The accumulator is 2N + $clog2(N_IN) bits wide, so it cannot overflow.
- At i=0 the accumulator is loaded with p; for i>0 it adds p.
- After i = N_IN−1 the FSM moves FETCH → OUT.
- In OUT, `out_data` = sat(acc >>> Q), with arithmetic shift (truncation toward −∞).
  - Saturation clamps to [−2^(N−1), 2^(N−1)−1].
  - `out_idx` = j.
  - `out_valid`=1 and is held, with data stable, until `out_ready`=1.
- On handshake, if j < N_OUT−1: j++, i cleared, FSM → FETCH. Otherwise FSM → DONE.
- DONE lasts one cycle with `done`=1 and `busy`=0, then FSM → IDLE.
- `start` outside IDLE is ignored. It is neither queued nor restarting a pass.
- `rst` at any time, including mid-pass: FSM → IDLE, all counters and the accumulator cleared, and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_addr`=BASE, `x_addr`=0, `out_valid`=0, `out_data`=0, `out_idx`=0.
- ROM and input-buffer read model: both register on the falling edge. `rom_data`/`x_data` for the address presented in cycle c are sampled at the rising edge ending cycle c. There are no bubbles.
- `start` accepted at edge E0. Cycles 1..N_IN present indices 0..N_IN−1. The accumulator updates at edges E1..E_N_IN.
- `out_valid` rises in cycle N_IN+1: latency start→first result is N_IN+1 cycles.
- For each neuron, the cycle after its handshake is index 0 of the next neuron.
- Full pass with `out_ready` tied high: N_OUT·(N_IN+1) busy cycles, then one `done` cycle.
- `out_ready` may be high before `out_valid`. The handshake completes in the first cycle where both are high.

## Structure
- Package `nar_seq_pkg`:
  - state enum (IDLE, FETCH, OUT, DONE)
  - saturate function
  - width helper constants (ACC_W = 2N + $clog2(N_IN))
- Sub-module `fxp_mac`: signed N×N multiply, load/accumulate select, saturating output with Q shift. The sequencer owns the counters, FSM and handshake.

## Test plan
- N=8, Q=7, N_IN=4, N_OUT=2, BASE=0; all weights 0x20, all x 0x40, `out_ready`=1 → two results of 0x40 (idx 0, 1) at cycles 5 and 10; `done` in cycle 11.
- All weights 0x40, all x 0x40 (sum 1.0) → `out_data`=0x7F. Weights 0x80, x 0x7F → 0x80.
- `out_ready` held low 7 cycles on neuron 0 → `out_valid`, `out_data` and `out_idx` stable throughout. Neuron 1 fetch starts the cycle after the handshake. Pass length grows by exactly 7.
- BASE=0x10, distinct weights per address → `rom_addr` sequence 0x10..0x17 with no gaps or repeats; `x_addr` wraps 0..3 twice.
- `start` pulsed during FETCH → ignored. Exactly N_OUT results and one `done`.
- `rst` asserted in the middle of neuron 1 → all outputs go to reset values immediately with no `done`. A new `start` then yields correct results from neuron 0.
